// File: rtl/max7219_display_driver.sv
// Serialises the stopwatch digits (mm:ss.cc) to a MAX7219 over cs_n/sck/mosi.
// After reset it sends a fixed init sequence, then sends six digit-register writes per upd strobe.
module max7219_display_driver #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [3:0]  INTENSITY = 4'hA
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ena,
  input  logic       upd,
  input  logic [3:0] ces_0X,
  input  logic [3:0] ces_X0,
  input  logic [3:0] sec_0X,
  input  logic [2:0] sec_X0,
  input  logic [3:0] min_0X,
  input  logic [2:0] min_X0,
  output logic       busy,
  output logic       cs_n,
  output logic       sck,
  output logic       mosi
);

  typedef enum logic [1:0] {INIT, IDLE, REFRESH} state_t;
  typedef enum logic [1:0] {SETUP, HIGH, LOW, GAP} phase_t;

  typedef struct packed {
    logic [2:0] min_x0;
    logic [3:0] min_0x;
    logic [2:0] sec_x0;
    logic [3:0] sec_0x;
    logic [3:0] ces_x0;
    logic [3:0] ces_0x;
  } digits_t;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [3:0] div_q, div_d;
  logic [3:0] bit_q, bit_d;
  logic [2:0] frame_q, frame_d;
  logic [2:0] frame_last;
  digits_t    snap_q, snap_d;
  logic [15:0] word;
  logic [3:0] digit;
  logic       dp;
  logic       active;
  logic       bit_out;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= INIT;
      phase_q <= SETUP;
      div_q   <= '0;
      bit_q   <= 4'd15;
      frame_q <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      snap_q  <= snap_d;
    end
  end

  assign frame_last = (state_q == INIT) ? 3'd4 : 3'd5;

  // NOTE: every output of this block gets a hold default first, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    div_d   = div_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    snap_d  = snap_q;
    if (ena) begin
      if (state_q == IDLE) begin
        if (upd) begin
          snap_d  = {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X};
          state_d = REFRESH;
          phase_d = SETUP;
          div_d   = '0;
          bit_d   = 4'd15;
          frame_d = '0;
        end
      end else if (div_q != DIV_LAST) begin
        div_d = div_q + 4'd1;
      end else begin
        div_d = '0;
        unique case (phase_q)
          SETUP: phase_d = HIGH;
          HIGH:  phase_d = LOW;
          LOW: begin
            if (bit_q == 4'd0) begin
              phase_d = GAP;
            end else begin
              bit_d   = bit_q - 4'd1;
              phase_d = HIGH;
            end
          end
          GAP: begin
            phase_d = SETUP;
            bit_d   = 4'd15;
            if (frame_q == frame_last) begin
              state_d = IDLE;
              frame_d = '0;
            end else begin
              frame_d = frame_q + 3'd1;
            end
          end
        endcase
      end
    end
  end

  // Frame word: fixed init table, or a digit-register write from the snapshot.
  always_comb begin
    digit = '0;
    dp    = 1'b0;
    word  = '0;
    case (frame_q)
      3'd0:    digit = snap_q.ces_0x;
      3'd1:    digit = snap_q.ces_x0;
      3'd2:    begin digit = snap_q.sec_0x; dp = 1'b1; end
      3'd3:    digit = {1'b0, snap_q.sec_x0};
      3'd4:    begin digit = snap_q.min_0x; dp = 1'b1; end
      3'd5:    digit = {1'b0, snap_q.min_x0};
      default: digit = '0;
    endcase
    if (state_q == INIT) begin
      case (frame_q)
        3'd0:    word = 16'h0C01;
        3'd1:    word = 16'h09FF;
        3'd2:    word = 16'h0B05;
        3'd3:    word = {12'h0A0, INTENSITY};
        default: word = 16'h0F00;
      endcase
    end else begin
      word = {5'd0, frame_q + 3'd1, dp, 3'b000, digit};
    end
  end

  always_comb begin
    bit_out = 1'b0;
    case (phase_q)
      SETUP:   bit_out = word[15];
      HIGH:    bit_out = word[bit_q];
      LOW:     bit_out = (bit_q == 4'd0) ? 1'b0 : word[bit_q - 4'd1];
      default: bit_out = 1'b0;
    endcase
  end

  // res gates the pins directly so an aborted frame releases the bus in the same cycle.
  assign active = (state_q != IDLE);
  assign busy   = res | active;
  assign cs_n   = res | ~active | (phase_q == GAP);
  assign sck    = ~res & active & (phase_q == HIGH);
  assign mosi   = ~res & active & bit_out;

endmodule

// File: tb/tb_max7219_display_driver.sv
// Bench for max7219_display_driver: decodes serial frames from two instances (CLK_DIV 2 and 1)
// and compares them, plus busy timing, against expected words queued when stimulus is driven.
module tb_max7219_display_driver;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       ena = 1'b1;
  logic       upd = 1'b0;
  logic       upd1 = 1'b0;
  logic [3:0] ces_0X = '0, ces_X0 = '0, sec_0X = '0, min_0X = '0;
  logic [2:0] sec_X0 = '0, min_X0 = '0;
  logic       busy0, cs_n0, sck0, mosi0;
  logic       busy1, cs_n1, sck1, mosi1;

  always #5 clk = ~clk;

  max7219_display_driver #(.CLK_DIV(2), .INTENSITY(4'hA)) dut (
    .clk(clk), .res(res), .ena(ena), .upd(upd),
    .ces_0X(ces_0X), .ces_X0(ces_X0), .sec_0X(sec_0X), .sec_X0(sec_X0),
    .min_0X(min_0X), .min_X0(min_X0),
    .busy(busy0), .cs_n(cs_n0), .sck(sck0), .mosi(mosi0)
  );

  max7219_display_driver #(.CLK_DIV(1), .INTENSITY(4'hA)) dut1 (
    .clk(clk), .res(res), .ena(ena), .upd(upd1),
    .ces_0X(ces_0X), .ces_X0(ces_X0), .sec_0X(sec_0X), .sec_X0(sec_X0),
    .min_0X(min_0X), .min_X0(min_X0),
    .busy(busy1), .cs_n(cs_n1), .sck(sck1), .mosi(mosi1)
  );

  typedef struct packed {
    logic [3:0]        ces_0x;
    logic [3:0]        ces_x0;
    logic [3:0]        sec_0x;
    logic [2:0]        sec_x0;
    logic [3:0]        min_0x;
    logic [2:0]        min_x0;
    logic [0:5][15:0]  words;
  } vec_t;

  vec_t        vecs [4];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_init(input int sel);
    logic [15:0] init_words [5];
    init_words = '{16'h0C01, 16'h09FF, 16'h0B05, 16'h0A0A, 16'h0F00};
    for (int k = 0; k < 5; k++) begin
      if (sel == 0) q0.push_back(init_words[k]);
      else          q1.push_back(init_words[k]);
    end
  endtask

  task automatic push_vec(input int sel, input vec_t v);
    for (int k = 0; k < 6; k++) begin
      if (sel == 0) q0.push_back(v.words[k]);
      else          q1.push_back(v.words[k]);
    end
  endtask

  task automatic drive_digits(input vec_t v);
    ces_0X = v.ces_0x; ces_X0 = v.ces_x0; sec_0X = v.sec_0x;
    sec_X0 = v.sec_x0; min_0X = v.min_0x; min_X0 = v.min_x0;
  endtask

  task automatic zero_digits();
    ces_0X = '0; ces_X0 = '0; sec_0X = '0; sec_X0 = '0; min_0X = '0; min_X0 = '0;
  endtask

  // One-cycle upd pulse; digits are cleared right after the capture edge.
  task automatic pulse(input int sel, input vec_t v);
    @(posedge clk); #1;
    drive_digits(v);
    if (sel == 0) upd = 1'b1;
    else          upd1 = 1'b1;
    push_vec(sel, v);
    @(posedge clk); #1;
    upd = 1'b0;
    upd1 = 1'b0;
    zero_digits();
  endtask

  // Counts enabled clock edges until busy is seen low; bounded by a cycle budget.
  task automatic wait_idle(input int sel, output int n);
    int cyc;
    cyc = 0;
    n = 0;
    do begin
      @(posedge clk);
      if (ena) n++;
      cyc++;
      @(negedge clk);
    end while (((sel == 0) ? busy0 : busy1) && cyc < 4000);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 res = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy0", busy0, 1);
    check("rst_cs_n0", cs_n0, 1);
    check("rst_sck0",  sck0,  0);
    check("rst_mosi0", mosi0, 0);
    check("rst_busy1", busy1, 1);
    check("rst_cs_n1", cs_n1, 1);
    check("rst_sck1",  sck1,  0);
    check("rst_mosi1", mosi1, 0);
    @(posedge clk); #1 res = 1'b0;
    q0.delete();
    q1.delete();
    push_init(0);
    push_init(1);
  endtask

  // Frame monitor: shift mosi in on every sck rise inside a cs_n-low window.
  logic [1:0]  cs_v, sck_v, mosi_v;
  assign cs_v   = {cs_n1, cs_n0};
  assign sck_v  = {sck1, sck0};
  assign mosi_v = {mosi1, mosi0};

  task automatic frame_done(input int sel, input logic [15:0] word, input int edges);
    check($sformatf("d%0d_sck_edges", sel), edges, 16);
    if (sel == 0) begin
      if (q0.size() == 0) begin
        total_cnt++;
        $display("FAIL d0_frame: unexpected frame 0x%h, none expected", word);
      end else check("d0_frame", word, q0.pop_front());
    end else begin
      if (q1.size() == 0) begin
        total_cnt++;
        $display("FAIL d1_frame: unexpected frame 0x%h, none expected", word);
      end else check("d1_frame", word, q1.pop_front());
    end
  endtask

  initial begin
    logic [15:0] shreg [2];
    int          edges [2];
    logic [1:0]  in_frame;
    logic [1:0]  prev_cs;
    logic [1:0]  prev_sck;
    in_frame = '0;
    prev_cs  = 2'b11;
    prev_sck = 2'b00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (res) begin
          in_frame[i] = 1'b0;
        end else begin
          if (!cs_v[i] && prev_cs[i]) begin
            in_frame[i] = 1'b1;
            shreg[i] = '0;
            edges[i] = 0;
          end
          if (in_frame[i] && !cs_v[i] && sck_v[i] && !prev_sck[i]) begin
            shreg[i] = {shreg[i][14:0], mosi_v[i]};
            edges[i]++;
          end
          if (in_frame[i] && cs_v[i] && !prev_cs[i]) begin
            in_frame[i] = 1'b0;
            frame_done(i, shreg[i], edges[i]);
          end
        end
        prev_cs[i]  = cs_v[i];
        prev_sck[i] = sck_v[i];
      end
    end
  end

  initial begin
    int         n;
    int         changes;
    logic [2:0] o_ref;

    vecs[0] = '{4'h6, 4'h5, 4'h4, 3'd3, 4'h2, 3'd1,
                {16'h0106, 16'h0205, 16'h0384, 16'h0403, 16'h0582, 16'h0601}};
    vecs[1] = '{4'h9, 4'h9, 4'h9, 3'd5, 4'h9, 3'd5,
                {16'h0109, 16'h0209, 16'h0389, 16'h0405, 16'h0589, 16'h0605}};
    vecs[2] = '{4'hF, 4'hE, 4'hD, 3'd7, 4'hC, 3'd6,
                {16'h010F, 16'h020E, 16'h038D, 16'h0407, 16'h058C, 16'h0606}};
    vecs[3] = '{4'h0, 4'h0, 4'h0, 3'd0, 4'h0, 3'd0,
                {16'h0100, 16'h0200, 16'h0380, 16'h0400, 16'h0580, 16'h0600}};

    // Init sequence after reset
    do_reset();
    wait_idle(0, n);
    check("init_busy_cycles", n, 340);

    // Table of refreshes
    for (int i = 0; i < 4; i++) begin
      pulse(0, vecs[i]);
      wait_idle(0, n);
      check($sformatf("refresh%0d_busy_cycles", i), n, 408);
    end

    // upd during third frame is dropped; upd at the busy-fall edge dropped; first IDLE cycle accepted
    pulse(0, vecs[0]);
    repeat (150) @(posedge clk);
    #1 upd = 1'b1;
    @(posedge clk); #1 upd = 1'b0;
    repeat (256) @(posedge clk);
    #1 upd = 1'b1;
    drive_digits(vecs[1]);
    @(negedge clk);
    check("busy_last_cycle", busy0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("upd_at_fall_dropped", busy0, 0);
    push_vec(0, vecs[1]);
    @(posedge clk); #1;
    upd = 1'b0;
    zero_digits();
    @(negedge clk);
    check("upd_first_idle_accepted", busy0, 1);
    wait_idle(0, n);
    check("refresh_after_idle_cycles", n, 408);

    // ena freeze for 50 cycles mid-bit
    pulse(0, vecs[2]);
    fork
      wait_idle(0, n);
      begin
        repeat (100) @(posedge clk);
        #1 ena = 1'b0;
        @(negedge clk);
        o_ref = {cs_n0, sck0, mosi0};
        check("freeze_in_frame_cs_n", cs_n0, 0);
        changes = 0;
        repeat (49) begin
          @(posedge clk);
          @(negedge clk);
          if ({cs_n0, sck0, mosi0} !== o_ref) changes++;
          if (!busy0) changes++;
        end
        @(posedge clk); #1 ena = 1'b1;
        check("freeze_output_changes", changes, 0);
      end
    join
    check("freeze_active_cycles", n, 408);

    // Reset pulse during the fourth init frame, while sck is high
    do_reset();
    repeat (206) @(posedge clk);
    #1 res = 1'b1;
    @(negedge clk);
    check("abort_cs_n", cs_n0, 1);
    check("abort_sck",  sck0,  0);
    check("abort_mosi", mosi0, 0);
    check("abort_busy", busy0, 1);
    @(posedge clk); #1 res = 1'b0;
    q0.delete();
    q1.delete();
    push_init(0);
    push_init(1);
    wait_idle(0, n);
    check("reinit_busy_cycles", n, 340);

    // CLK_DIV=1 instance: 34 cycles per frame, raw 0xF digit
    pulse(1, vecs[2]);
    wait_idle(1, n);
    check("div1_refresh_cycles", n, 204);

    repeat (5) @(posedge clk);
    check("d0_queue_drained", q0.size(), 0);
    check("d1_queue_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
